axi_rd_arbiter: RTL and testbench
=================================

AXI_RD_ARBITER -- requirements
Module: ysyx_22050019_axi_rd_arbiter

Interface
REQ-001 The block SHALL use parameter AXI_ADDR_WIDTH, default 64, as the read-address width.
REQ-002 The block SHALL use parameter AXI_DATA_WIDTH, default 64, as the read-data width.
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset; clk and rst are the only clock and reset ports.
REQ-004 clk  in  1  system clock, all state updates on rising edge.
REQ-005 rst  in  1  asynchronous active-high reset.
REQ-006 ifu_ar_valid_i  in  1  IFU read-address request.
REQ-007 ifu_ar_ready_o  out  1  IFU read-address accepted.
REQ-008 ifu_ar_addr_i  in  AXI_ADDR_WIDTH  IFU read address.
REQ-009 ifu_r_valid_o  out  1  IFU read data valid.
REQ-010 ifu_r_ready_i  in  1  IFU ready for read data.
REQ-011 ifu_r_data_o  out  AXI_DATA_WIDTH  IFU read data.
REQ-012 ifu_r_resp_o  out  2  IFU read response.
REQ-013 lsu_ar_valid_i, lsu_ar_ready_o, lsu_ar_addr_i, lsu_r_valid_o, lsu_r_ready_i, lsu_r_data_o, lsu_r_resp_o SHALL mirror REQ-006..012 for the LSU, with the same directions and widths.
REQ-014 axi_ar_valid_o, axi_ar_ready_i, axi_ar_addr_o, axi_r_valid_i, axi_r_ready_o, axi_r_data_i, axi_r_resp_i SHALL be the single downstream read port to the SRAM slave, with the same widths.

Function
REQ-015 The arbiter SHALL implement states IDLE, AR, and R, plus a 1-bit grant register (0=IFU, 1=LSU) and a 1-bit last-grant register.
- The grant and last-grant registers update only on leaving IDLE.
REQ-016 In IDLE, transition to AR on the next edge if either ar_valid is high.
- Only one requester valid: grant that requester.
- Both valid: grant the requester that was NOT in last-grant (round-robin).
- On this transition, last-grant SHALL be loaded with the new grant.
REQ-017 In IDLE, all ready and valid outputs to both masters and to the slave SHALL be 0.
- Arbitration latency is one cycle: a request seen in IDLE reaches the slave on the next cycle.
REQ-018 In AR, the slave ar signals SHALL be driven combinationally from the granted master:
- axi_ar_valid_o = granted ar_valid.
- axi_ar_addr_o = granted ar_addr.
- The granted ar_ready_o = axi_ar_ready_i.
- The non-granted ar_ready_o SHALL be 0.
REQ-019 AR SHALL move to R on the edge where axi_ar_valid_o and axi_ar_ready_i are both high; otherwise it stays in AR.
REQ-020 In R, the slave r signals SHALL be routed combinationally to the granted master:
- Granted r_valid, r_data, r_resp = slave r_valid, r_data, r_resp.
- axi_r_ready_o = granted r_ready.
- The non-granted r_valid, r_data, r_resp SHALL be 0.
REQ-021 R SHALL return to IDLE on the edge where axi_r_valid_i and axi_r_ready_o are both high.
- One transaction is outstanding at a time.
- A new grant needs a further IDLE cycle, so back-to-back transactions have a 1-cycle bubble.
REQ-022 A request from the non-granted master SHALL be held off, not dropped.
- That master keeps ar_valid asserted per the AXI rule.
- It SHALL be granted in the next IDLE.
REQ-023 Address and data SHALL pass through without registering, width change, or modification.
REQ-024 The state register SHALL leave only the legal encodings IDLE, AR, and R; any illegal encoding SHALL transition to IDLE.
REQ-025 The arbiter SHALL generate no transaction when no master is valid, and SHALL never assert axi_ar_valid_o while in R.

Reset
REQ-026 On rst high, regardless of clk:
- State SHALL go to IDLE.
- Grant SHALL go to 0.
- Last-grant SHALL go to 1, so the IFU wins the first tie.
- Every output SHALL be 0.
REQ-027 Reset asserted during AR or R SHALL abort the transaction, with no response delivered to either master.
REQ-028 After rst is released, arbitration SHALL begin on the first rising edge with a request present.

Verification
REQ-029 Only the IFU requests addr 0x8000_0000; the slave gives ar_ready in cycle 2 and r_data 0x1122_3344_5566_7788 in cycle 4 -> IFU receives that data with resp 0; LSU outputs remain 0 throughout.
REQ-030 IFU and LSU both request in the same cycle after reset -> IFU is served first; LSU is served next, after one IDLE cycle; lsu_ar_ready_o stays 0 until then.
REQ-031 Both request continuously for 4 transactions -> grants alternate IFU, LSU, IFU, LSU.
REQ-032 The slave holds ar_ready low for 5 cycles, then r_valid is high while the master's r_ready is low for 3 cycles -> state holds in AR, then in R; exactly one handshake occurs per channel.
REQ-033 rst is pulsed asynchronously (not on a clk edge) while in R -> outputs go to 0 immediately; the next request is granted cleanly with the IFU winning a tie.

Source files
------------

// File: rtl/axi_rd_arbiter.sv
// AXI read-channel arbiter: shares one downstream read port between the IFU and the LSU.
// Ties are resolved round-robin. Only one transaction is outstanding, with an idle cycle between grants.
module axi_rd_arbiter #(
    parameter int AXI_ADDR_WIDTH = 64,
    parameter int AXI_DATA_WIDTH = 64
) (
    input  logic                      clk,
    input  logic                      rst,

    input  logic                      ifu_ar_valid_i,
    output logic                      ifu_ar_ready_o,
    input  logic [AXI_ADDR_WIDTH-1:0] ifu_ar_addr_i,
    output logic                      ifu_r_valid_o,
    input  logic                      ifu_r_ready_i,
    output logic [AXI_DATA_WIDTH-1:0] ifu_r_data_o,
    output logic [1:0]                ifu_r_resp_o,

    input  logic                      lsu_ar_valid_i,
    output logic                      lsu_ar_ready_o,
    input  logic [AXI_ADDR_WIDTH-1:0] lsu_ar_addr_i,
    output logic                      lsu_r_valid_o,
    input  logic                      lsu_r_ready_i,
    output logic [AXI_DATA_WIDTH-1:0] lsu_r_data_o,
    output logic [1:0]                lsu_r_resp_o,

    output logic                      axi_ar_valid_o,
    input  logic                      axi_ar_ready_i,
    output logic [AXI_ADDR_WIDTH-1:0] axi_ar_addr_o,
    input  logic                      axi_r_valid_i,
    output logic                      axi_r_ready_o,
    input  logic [AXI_DATA_WIDTH-1:0] axi_r_data_i,
    input  logic [1:0]                axi_r_resp_i
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        AR   = 2'b01,
        R    = 2'b10
    } state_e;

    state_e state_q, state_d;
    logic   grant_q, grant_d;
    logic   lastGrant_q, lastGrant_d;

    // lastGrant resets to LSU so the IFU wins the first tie after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            grant_q     <= 1'b0;
            lastGrant_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            lastGrant_q <= lastGrant_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        grant_d        = grant_q;
        lastGrant_d    = lastGrant_q;
        ifu_ar_ready_o = 1'b0;
        ifu_r_valid_o  = 1'b0;
        ifu_r_data_o   = '0;
        ifu_r_resp_o   = 2'b00;
        lsu_ar_ready_o = 1'b0;
        lsu_r_valid_o  = 1'b0;
        lsu_r_data_o   = '0;
        lsu_r_resp_o   = 2'b00;
        axi_ar_valid_o = 1'b0;
        axi_ar_addr_o  = '0;
        axi_r_ready_o  = 1'b0;

        case (state_q)
            IDLE: begin
                if (ifu_ar_valid_i || lsu_ar_valid_i) begin
                    state_d = AR;
                    if (ifu_ar_valid_i && lsu_ar_valid_i) begin
                        grant_d = ~lastGrant_q;
                    end else begin
                        grant_d = lsu_ar_valid_i;
                    end
                    lastGrant_d = grant_d;
                end
            end
            AR: begin
                if (grant_q) begin
                    axi_ar_valid_o = lsu_ar_valid_i;
                    axi_ar_addr_o  = lsu_ar_addr_i;
                    lsu_ar_ready_o = axi_ar_ready_i;
                end else begin
                    axi_ar_valid_o = ifu_ar_valid_i;
                    axi_ar_addr_o  = ifu_ar_addr_i;
                    ifu_ar_ready_o = axi_ar_ready_i;
                end
                if (axi_ar_valid_o && axi_ar_ready_i) begin
                    state_d = R;
                end
            end
            R: begin
                if (grant_q) begin
                    lsu_r_valid_o = axi_r_valid_i;
                    lsu_r_data_o  = axi_r_data_i;
                    lsu_r_resp_o  = axi_r_resp_i;
                    axi_r_ready_o = lsu_r_ready_i;
                end else begin
                    ifu_r_valid_o = axi_r_valid_i;
                    ifu_r_data_o  = axi_r_data_i;
                    ifu_r_resp_o  = axi_r_resp_i;
                    axi_r_ready_o = ifu_r_ready_i;
                end
                if (axi_r_valid_i && axi_r_ready_o) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Randomized bench for axi_rd_arbiter: two requesting masters and a slave with random stalls.
// A transaction-level model predicts every routed output once per cycle.
module tb_axi_rd_arbiter;

    logic        clk;
    logic        rst;
    logic        ifu_ar_valid_i, ifu_ar_ready_o, ifu_r_valid_o, ifu_r_ready_i;
    logic [63:0] ifu_ar_addr_i, ifu_r_data_o;
    logic [1:0]  ifu_r_resp_o;
    logic        lsu_ar_valid_i, lsu_ar_ready_o, lsu_r_valid_o, lsu_r_ready_i;
    logic [63:0] lsu_ar_addr_i, lsu_r_data_o;
    logic [1:0]  lsu_r_resp_o;
    logic        axi_ar_valid_o, axi_ar_ready_i, axi_r_valid_i, axi_r_ready_o;
    logic [63:0] axi_ar_addr_o, axi_r_data_i;
    logic [1:0]  axi_r_resp_i;

    int checkCount = 0;
    int errorCount = 0;

    // Master agents: index 0 is the IFU, index 1 is the LSU.
    logic [1:0]  reqPend;
    logic [63:0] reqAddr [2];
    logic [1:0]  rReady;
    logic        forceTie;

    // Slave agent state.
    logic        slvArReady, slvRValid, slvHasData;
    logic [63:0] slvAddr, slvRData;
    logic [1:0]  slvRResp;
    int          slvDelay;

    // Transaction model: phase 0 = bus free, 1 = address owned, 2 = data owned.
    int   mPhase;
    logic mOwner;
    logic lastWinner;
    int   doneCount;

    axi_rd_arbiter #(.AXI_ADDR_WIDTH(64), .AXI_DATA_WIDTH(64)) dut (
        .clk(clk), .rst(rst),
        .ifu_ar_valid_i(ifu_ar_valid_i), .ifu_ar_ready_o(ifu_ar_ready_o), .ifu_ar_addr_i(ifu_ar_addr_i),
        .ifu_r_valid_o(ifu_r_valid_o), .ifu_r_ready_i(ifu_r_ready_i), .ifu_r_data_o(ifu_r_data_o),
        .ifu_r_resp_o(ifu_r_resp_o),
        .lsu_ar_valid_i(lsu_ar_valid_i), .lsu_ar_ready_o(lsu_ar_ready_o), .lsu_ar_addr_i(lsu_ar_addr_i),
        .lsu_r_valid_o(lsu_r_valid_o), .lsu_r_ready_i(lsu_r_ready_i), .lsu_r_data_o(lsu_r_data_o),
        .lsu_r_resp_o(lsu_r_resp_o),
        .axi_ar_valid_o(axi_ar_valid_o), .axi_ar_ready_i(axi_ar_ready_i), .axi_ar_addr_o(axi_ar_addr_o),
        .axi_r_valid_i(axi_r_valid_i), .axi_r_ready_o(axi_r_ready_o), .axi_r_data_i(axi_r_data_i),
        .axi_r_resp_i(axi_r_resp_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] slvData(input logic [63:0] addr);
        return addr ^ 64'h1122_3344_5566_7788;
    endfunction

    task automatic checkOutput(input string tag, input logic [255:0] observed, input logic [255:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic logic [255:0] allOutputs();
        return {ifu_ar_ready_o, ifu_r_valid_o, ifu_r_data_o, ifu_r_resp_o,
                lsu_ar_ready_o, lsu_r_valid_o, lsu_r_data_o, lsu_r_resp_o,
                axi_ar_valid_o, axi_ar_addr_o, axi_r_ready_o};
    endfunction

    // Masters may raise a new request whenever they have none pending and hold it until accepted.
    task automatic applyStimulus();
        for (int m = 0; m < 2; m++) begin
            if (!reqPend[m] && (forceTie || $urandom_range(2) == 0)) begin
                reqPend[m] = 1'b1;
                reqAddr[m] = {$urandom, $urandom};
            end
            rReady[m] = ($urandom_range(2) != 0);
        end
        forceTie   = 1'b0;
        slvArReady = 1'($urandom_range(1));
        if (slvHasData && !slvRValid) begin
            if (slvDelay == 0) slvRValid = 1'b1;
            else slvDelay--;
        end
        slvRData = slvRValid ? slvData(slvAddr) : {$urandom, $urandom};
        slvRResp = slvRValid ? slvAddr[1:0] : 2'($urandom_range(3));

        ifu_ar_valid_i = reqPend[0];
        ifu_ar_addr_i  = reqAddr[0];
        ifu_r_ready_i  = rReady[0];
        lsu_ar_valid_i = reqPend[1];
        lsu_ar_addr_i  = reqAddr[1];
        lsu_r_ready_i  = rReady[1];
        axi_ar_ready_i = slvArReady;
        axi_r_valid_i  = slvRValid;
        axi_r_data_i   = slvRData;
        axi_r_resp_i   = slvRResp;
    endtask

    // Predict this cycle's outputs, compare, then advance the model across the coming edge.
    task automatic checkAndAdvance();
        logic        expArValid, expRReady;
        logic [63:0] expArAddr;
        logic [1:0]  expArRdy;
        logic [66:0] expR [2];
        logic [63:0] gotData;
        expArValid = 1'b0;
        expArAddr  = '0;
        expArRdy   = 2'b00;
        expRReady  = 1'b0;
        expR[0]    = '0;
        expR[1]    = '0;
        if (mPhase == 1) begin
            expArValid       = reqPend[mOwner];
            expArAddr        = reqAddr[mOwner];
            expArRdy[mOwner] = slvArReady;
        end else if (mPhase == 2) begin
            expRReady    = rReady[mOwner];
            expR[mOwner] = {slvRValid, slvRData, slvRResp};
        end
        checkOutput("arPath", {axi_ar_valid_o, axi_ar_addr_o, ifu_ar_ready_o, lsu_ar_ready_o},
                    {expArValid, expArAddr, expArRdy[0], expArRdy[1]});
        checkOutput("ifuR", {ifu_r_valid_o, ifu_r_data_o, ifu_r_resp_o}, expR[0]);
        checkOutput("lsuR", {lsu_r_valid_o, lsu_r_data_o, lsu_r_resp_o}, expR[1]);
        checkOutput("rReady", axi_r_ready_o, expRReady);

        if (mPhase == 0) begin
            if (reqPend != 2'b00) begin
                mOwner     = (reqPend == 2'b11) ? ~lastWinner : reqPend[1];
                lastWinner = mOwner;
                mPhase     = 1;
            end
        end else if (mPhase == 1) begin
            if (slvArReady) begin
                mPhase          = 2;
                reqPend[mOwner] = 1'b0;
                slvHasData      = 1'b1;
                slvAddr         = axi_ar_addr_o;
                slvDelay        = $urandom_range(3);
                slvRValid       = 1'b0;
            end
        end else if (mPhase == 2) begin
            if (slvRValid && rReady[mOwner]) begin
                gotData = mOwner ? lsu_r_data_o : ifu_r_data_o;
                checkOutput(mOwner ? "lsuE2E" : "ifuE2E", gotData, slvData(reqAddr[mOwner] ^ 64'h0 ^ 64'h0) ^ slvData(reqAddr[mOwner]) ^ slvData(slvAddr));
                mPhase     = 0;
                slvHasData = 1'b0;
                slvRValid  = 1'b0;
                doneCount++;
            end
        end
    endtask

    task automatic resetModel();
        reqPend    = 2'b00;
        rReady     = 2'b00;
        forceTie   = 1'b1;
        slvHasData = 1'b0;
        slvRValid  = 1'b0;
        slvDelay   = 0;
        mPhase     = 0;
        lastWinner = 1'b1;
        ifu_ar_valid_i = 1'b0;
        lsu_ar_valid_i = 1'b0;
    endtask

    initial begin
        bit didPulse;
        didPulse  = 1'b0;
        doneCount = 0;
        slvAddr   = '0;
        reqAddr[0] = '0;
        reqAddr[1] = '0;
        rst = 1'b1;
        ifu_ar_valid_i = 1'b1;
        lsu_ar_valid_i = 1'b1;
        ifu_ar_addr_i  = 64'h8000_0000;
        lsu_ar_addr_i  = 64'h8000_1000;
        ifu_r_ready_i  = 1'b1;
        lsu_r_ready_i  = 1'b1;
        axi_ar_ready_i = 1'b1;
        axi_r_valid_i  = 1'b1;
        axi_r_data_i   = 64'hDEAD_BEEF_CAFE_F00D;
        axi_r_resp_i   = 2'b11;
        #23;
        checkOutput("resetOutputs", allOutputs(), '0);
        resetModel();
        #1 rst = 1'b0;

        for (int cycle = 0; cycle < 3000; cycle++) begin
            @(negedge clk);
            applyStimulus();
            #1;
            if (!didPulse && cycle > 1500 && mPhase == 2) begin
                checkAndAdvance();
                #2 rst = 1'b1;
                #1 checkOutput("asyncResetOutputs", allOutputs(), '0);
                resetModel();
                rst = 1'b0;
                didPulse = 1'b1;
            end else begin
                checkAndAdvance();
            end
        end
        checkOutput("progress", (doneCount > 100), 1'b1);
        checkOutput("resetPulsed", didPulse, 1'b1);
        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
